// File: rtl/ram_responder.sv
// Word-addressed behavioural RAM that stalls each request with BUSY for LAT+1 cycles, then completes it with ACCESS.
// Optional feature macro: RAM_BOUNDS_CHECK_EN (report ERROR for addresses beyond the array instead of wrapping).
module ram_responder #(
  parameter int unsigned LAT        = 2,
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] memaddr,
  input  logic [31:0] memstore,
  input  logic        memREN,
  input  logic        memWEN,
  output logic [31:0] ramload,
  output logic [1:0]  ramstate
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ram_state_e;

  localparam int unsigned Words = 1 << DEPTH_LOG2;

  logic                  pv_q, pv_d;
  logic [31:0]           paddr_q, paddr_d;
  logic [31:0]           pstore_q, pstore_d;
  logic                  pren_q, pren_d;
  logic                  pwen_q, pwen_d;
  logic [3:0]            cnt_q, cnt_d;

  logic [31:0]           mem [Words];
  logic [DEPTH_LOG2-1:0] index;
  logic                  present;
  logic                  conflict;
  logic                  held;
  logic                  outOfRange;
  logic                  memWrite;
  logic                  unused_addr;
  ram_state_e            state;

  assign present  = memREN ^ memWEN;
  assign conflict = memREN & memWEN;
  assign index    = memaddr[DEPTH_LOG2+1:2];

`ifdef RAM_BOUNDS_CHECK_EN
  assign outOfRange  = |memaddr[31:DEPTH_LOG2+2];
  assign unused_addr = ^memaddr[1:0];
`else
  assign outOfRange  = 1'b0;
  assign unused_addr = ^{memaddr[31:DEPTH_LOG2+2], memaddr[1:0]};
`endif

  // Write data only matters for matching when the request is a write.
  assign held = present && pv_q && (paddr_q == memaddr) && (pren_q == memREN) &&
                (pwen_q == memWEN) && (!memWEN || (pstore_q == memstore));

  always_comb begin
    pv_d     = present;
    paddr_d  = memaddr;
    pstore_d = memstore;
    pren_d   = memREN;
    pwen_d   = memWEN;
    cnt_d    = cnt_q;
    state    = FREE;
    if (!nRST) begin
      state = FREE;
    end else if (conflict) begin
      state = ERROR;
    end else if (!present) begin
      state = FREE;
    end else if (outOfRange) begin
      state = ERROR;
    end else if (!held) begin
      state = BUSY;
      cnt_d = 4'(LAT);
    end else if (cnt_q != 4'd0) begin
      state = BUSY;
      cnt_d = cnt_q - 4'd1;
    end else begin
      state = ACCESS;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pv_q     <= 1'b0;
      paddr_q  <= '0;
      pstore_q <= '0;
      pren_q   <= 1'b0;
      pwen_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      pv_q     <= pv_d;
      paddr_q  <= paddr_d;
      pstore_q <= pstore_d;
      pren_q   <= pren_d;
      pwen_q   <= pwen_d;
      cnt_q    <= cnt_d;
    end
  end

  // Memory contents deliberately survive reset; state is FREE while nRST is low, so no write can slip in.
  assign memWrite = (state == ACCESS) && memWEN;

  always_ff @(posedge CLK) begin
    if (memWrite) begin
      mem[index] <= memstore;
    end
  end

  assign ramstate = state;
  assign ramload  = ((state == ACCESS) && memREN) ? mem[index] : 32'd0;

endmodule
